gfx_stream_arb: RTL and testbench

Round-robin arbiter sharing one registered pixel-stream output (x, y, pixel) among NUM_SRC drawing engines (rect fill, line, future shape primitives). Each engine requests the port, is granted it for one whole packet (a primitive's pixel burst ending with a `last` beat), then releases it. It replaces ad-hoc state-driven muxes in shape sequencers and sits between the primitive engines and the framebuffer writer.

---
 rtl/gfx_stream_arb_pkg.sv | 15 +
 rtl/gfx_stream_arb_if.sv | 36 +++
 rtl/gfx_rr_pick.sv | 41 ++++
 rtl/gfx_stream_arb.sv | 147 ++++++++++++++
 tb/tb_gfx_stream_arb.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_stream_arb_pkg.sv
// Shared types and helpers for the pixel-stream round-robin arbiter.
package gfx_stream_arb_pkg;

  // StArb: choosing the next source; StBusy: one source owns the port until its last beat.
  typedef enum logic [0:0] {
    StArb  = 1'b0,
    StBusy = 1'b1
  } state_t;

  // Width of a source index; at least one bit even for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gfx_stream_arb_if.sv
// Bundle of the per-source request/beat signals and the shared output beat.
interface gfx_stream_arb_if #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned H_WIDTH     = 12,
  parameter int unsigned V_WIDTH     = 12,
  parameter int unsigned PIXEL_WIDTH = 12
);

  logic [NUM_SRC-1:0]             s_req;
  logic [NUM_SRC-1:0]             s_gnt;
  logic [NUM_SRC-1:0]             s_gfx_valid;
  logic [NUM_SRC*H_WIDTH-1:0]     s_gfx_x;
  logic [NUM_SRC*V_WIDTH-1:0]     s_gfx_y;
  logic [NUM_SRC*PIXEL_WIDTH-1:0] s_gfx_pixel;
  logic [NUM_SRC-1:0]             s_gfx_last;
  logic [NUM_SRC-1:0]             s_gfx_ready;
  logic                           m_gfx_valid;
  logic [H_WIDTH-1:0]             m_gfx_x;
  logic [V_WIDTH-1:0]             m_gfx_y;
  logic [PIXEL_WIDTH-1:0]         m_gfx_pixel;
  logic                           m_gfx_last;
  logic                           m_gfx_ready;

  // Arbiter side: owns grants, per-source ready and the output beat.
  modport master (
    input  s_req, s_gfx_valid, s_gfx_x, s_gfx_y, s_gfx_pixel, s_gfx_last, m_gfx_ready,
    output s_gnt, s_gfx_ready, m_gfx_valid, m_gfx_x, m_gfx_y, m_gfx_pixel, m_gfx_last
  );

  // Engine/framebuffer side.
  modport slave (
    output s_req, s_gfx_valid, s_gfx_x, s_gfx_y, s_gfx_pixel, s_gfx_last, m_gfx_ready,
    input  s_gnt, s_gfx_ready, m_gfx_valid, m_gfx_x, m_gfx_y, m_gfx_pixel, m_gfx_last
  );

endinterface

// File: rtl/gfx_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module gfx_rr_pick
  import gfx_stream_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] NumSrcW = (IDX_W + 1)'(NUM_SRC);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan candidates ptr, ptr+1, ... with explicit wrap so non-power-of-two counts stay in range.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= NumSrcW) begin
        sum = sum - NumSrcW;
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx_stream_arb.sv
// Packet-granular round-robin arbiter feeding one registered pixel-stream output.
module gfx_stream_arb
  import gfx_stream_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned H_WIDTH     = 12,
  parameter int unsigned V_WIDTH     = 12,
  parameter int unsigned PIXEL_WIDTH = 12
) (
  input logic               clk,
  input logic               rst_n,
  gfx_stream_arb_if.master  bus
);

  localparam int unsigned     IdxW    = idx_width(NUM_SRC);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SRC - 1);

  state_t                 state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        sel_q, sel_d;
  logic [NUM_SRC-1:0]     gnt_q, gnt_d;
  logic [NUM_SRC-1:0]     ready;
  logic                   m_valid_q, m_valid_d;
  logic                   m_last_q, m_last_d;
  logic [H_WIDTH-1:0]     m_x_q, m_x_d;
  logic [V_WIDTH-1:0]     m_y_q, m_y_d;
  logic [PIXEL_WIDTH-1:0] m_pix_q, m_pix_d;

  logic [NUM_SRC-1:0]     pick_gnt;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_any;

  logic [H_WIDTH-1:0]     src_x   [NUM_SRC];
  logic [V_WIDTH-1:0]     src_y   [NUM_SRC];
  logic [PIXEL_WIDTH-1:0] src_pix [NUM_SRC];

  logic out_ready;
  logic accept;
  logic sel_last;

  gfx_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IdxW)
  ) u_pick (
    .req (bus.s_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Split the packed per-source beat buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_x[i]   = bus.s_gfx_x[i*H_WIDTH +: H_WIDTH];
      src_y[i]   = bus.s_gfx_y[i*V_WIDTH +: V_WIDTH];
      src_pix[i] = bus.s_gfx_pixel[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  // Output slot is free when empty or draining this cycle; no skid buffer.
  assign out_ready = !m_valid_q || bus.m_gfx_ready;
  assign accept    = (state_q == StBusy) && bus.s_gfx_valid[sel_q] && out_ready;
  assign sel_last  = bus.s_gfx_last[sel_q];

  // Arbitration FSM: grant on request, release and advance ptr on the accepted last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ready   = '0;
    case (state_q)
      StArb: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          sel_d   = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        ready[sel_q] = out_ready;
        if (accept && sel_last) begin
          gnt_d   = '0;
          ptr_d   = (sel_q == LastIdx) ? '0 : sel_q + 1'b1;
          state_d = StArb;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StArb;
      end
    endcase
  end

  // Output register: load on accept, drop valid once consumed, otherwise hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_x_d     = m_x_q;
    m_y_d     = m_y_q;
    m_pix_d   = m_pix_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_last_d  = sel_last;
      m_x_d     = src_x[sel_q];
      m_y_d     = src_y[sel_q];
      m_pix_d   = src_pix[sel_q];
    end else if (bus.m_gfx_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StArb;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_x_q     <= '0;
      m_y_q     <= '0;
      m_pix_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_x_q     <= m_x_d;
      m_y_q     <= m_y_d;
      m_pix_q   <= m_pix_d;
    end
  end

  assign bus.s_gnt       = gnt_q;
  assign bus.s_gfx_ready = ready;
  assign bus.m_gfx_valid = m_valid_q;
  assign bus.m_gfx_last  = m_last_q;
  assign bus.m_gfx_x     = m_x_q;
  assign bus.m_gfx_y     = m_y_q;
  assign bus.m_gfx_pixel = m_pix_q;

endmodule

// File: tb/tb_gfx_stream_arb.sv
// Directed bench for gfx_stream_arb: a 2-source and a 3-source instance.
module tb_gfx_stream_arb;

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 12;
  localparam int unsigned PW = 12;

  // Hand-computed per-step expectations.
  localparam int ContGnt  [9] = '{1, 1, 0, 2, 2, 0, 1, 1, 0};
  localparam int ContMv   [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
  localparam int ContX    [9] = '{0, 10, 11, 11, 20, 21, 21, 30, 31};
  localparam int ContLast [9] = '{0, 0, 1, 1, 0, 1, 1, 0, 1};

  localparam int BpMr   [6] = '{1, 0, 0, 1, 1, 1};
  localparam int BpRdy  [6] = '{1, 0, 0, 1, 1, 0};
  localparam int BpMv   [6] = '{1, 1, 1, 1, 1, 0};
  localparam int BpX    [6] = '{40, 40, 40, 41, 42, 42};
  localparam int BpLast [6] = '{0, 0, 0, 0, 1, 1};
  localparam int BpGnt  [6] = '{1, 1, 1, 1, 0, 0};

  localparam int IsoGnt  [5] = '{1, 1, 1, 0, 0};
  localparam int IsoRdy  [5] = '{0, 1, 1, 1, 0};
  localparam int IsoMv   [5] = '{0, 1, 1, 1, 0};
  localparam int IsoX    [5] = '{42, 50, 51, 52, 52};
  localparam int IsoLast [5] = '{1, 0, 0, 1, 1};

  localparam int WrapGnt [12] = '{1, 0, 2, 0, 4, 0, 1, 0, 2, 0, 4, 0};
  localparam int WrapMv  [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  localparam int WrapX   [12] = '{0, 0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  gfx_stream_arb_if #(.NUM_SRC(2), .H_WIDTH(HW), .V_WIDTH(VW), .PIXEL_WIDTH(PW)) a ();
  gfx_stream_arb_if #(.NUM_SRC(3), .H_WIDTH(HW), .V_WIDTH(VW), .PIXEL_WIDTH(PW)) b ();

  gfx_stream_arb #(.NUM_SRC(2), .H_WIDTH(HW), .V_WIDTH(VW), .PIXEL_WIDTH(PW)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.master)
  );

  gfx_stream_arb #(.NUM_SRC(3), .H_WIDTH(HW), .V_WIDTH(VW), .PIXEL_WIDTH(PW)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.master)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Source-engine model for the 2-source instance.
  logic [1:0]  act;
  logic [1:0]  rogue;
  logic [1:0]  rdy_seen;
  int unsigned base [2];
  int unsigned plen [2];
  int unsigned bidx [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive2();
    for (int i = 0; i < 2; i++) begin
      a.s_req[i]                 = act[i];
      a.s_gfx_valid[i]           = act[i] | rogue[i];
      a.s_gfx_x[i*HW +: HW]      = HW'(base[i] + bidx[i]);
      a.s_gfx_y[i*VW +: VW]      = VW'(5 + i);
      a.s_gfx_pixel[i*PW +: PW]  = (i == 0) ? 12'hF00 : 12'h0F0;
      a.s_gfx_last[i]            = rogue[i] | (bidx[i] == plen[i] - 1);
    end
  endtask

  task automatic start_pkt(input int s, input int unsigned bx, input int unsigned n);
    act[s]  = 1'b1;
    base[s] = bx;
    plen[s] = n;
    bidx[s] = 0;
    drive2();
  endtask

  // One clock: record ready mid-cycle, then advance sources whose beat was taken.
  task automatic step2();
    logic [1:0] acc;
    @(negedge clk);
    rdy_seen = a.s_gfx_ready;
    acc      = a.s_gfx_ready & a.s_gfx_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i] && act[i]) begin
        if (bidx[i] == plen[i] - 1) begin
          act[i]  = 1'b0;
          bidx[i] = 0;
        end else begin
          bidx[i]++;
        end
      end
    end
    drive2();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    act   = '0;
    rogue = '0;
    drive2();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    act      = '0;
    rogue    = '0;
    rdy_seen = '0;
    for (int i = 0; i < 2; i++) begin
      base[i] = 0;
      plen[i] = 1;
      bidx[i] = 0;
    end
    drive2();
    a.m_gfx_ready = 1'b1;
    b.s_req = '0;
    b.s_gfx_valid = '0;
    b.s_gfx_last = '0;
    b.s_gfx_x = '0;
    b.s_gfx_y = '0;
    b.s_gfx_pixel = '0;
    b.m_gfx_ready = 1'b1;

    // Reset state.
    #12;
    check_eq("rst_gnt", 32'(a.s_gnt), 32'd0);
    check_eq("rst_ready", 32'(a.s_gfx_ready), 32'd0);
    check_eq("rst_mvalid", 32'(a.m_gfx_valid), 32'd0);
    check_eq("rst_mlast", 32'(a.m_gfx_last), 32'd0);
    check_eq("rst_mxyp", 32'({a.m_gfx_x, a.m_gfx_y, a.m_gfx_pixel}), 32'd0);
    check_eq("rst_gnt3", 32'(b.s_gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single source, 4 beats back to back.
    start_pkt(0, 0, 4);
    step2();
    check_eq("single_gnt", 32'(a.s_gnt), 32'd1);
    check_eq("single_mv0", 32'(a.m_gfx_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step2();
      check_eq($sformatf("single_rdy[%0d]", k), 32'(rdy_seen), 32'd1);
      check_eq($sformatf("single_mv[%0d]", k), 32'(a.m_gfx_valid), 32'd1);
      check_eq($sformatf("single_x[%0d]", k), 32'(a.m_gfx_x), 32'(k));
      check_eq($sformatf("single_y[%0d]", k), 32'(a.m_gfx_y), 32'd5);
      check_eq($sformatf("single_pix[%0d]", k), 32'(a.m_gfx_pixel), 32'h0F00);
      check_eq($sformatf("single_last[%0d]", k), 32'(a.m_gfx_last), 32'(k == 3));
    end
    check_eq("single_gnt_rel", 32'(a.s_gnt), 32'd0);
    step2();
    check_eq("single_mv_end", 32'(a.m_gfx_valid), 32'd0);
    check_eq("single_rdy_end", 32'(rdy_seen), 32'd0);

    // Contention from reset, then src0 re-requests behind src1.
    do_reset();
    start_pkt(0, 10, 2);
    start_pkt(1, 20, 2);
    for (int k = 0; k < 9; k++) begin
      step2();
      if (k == 2) start_pkt(0, 30, 2);
      check_eq($sformatf("cont_gnt[%0d]", k), 32'(a.s_gnt), 32'(ContGnt[k]));
      check_eq($sformatf("cont_mv[%0d]", k), 32'(a.m_gfx_valid), 32'(ContMv[k]));
      check_eq($sformatf("cont_x[%0d]", k), 32'(a.m_gfx_x), 32'(ContX[k]));
      check_eq($sformatf("cont_last[%0d]", k), 32'(a.m_gfx_last), 32'(ContLast[k]));
    end

    // Backpressure with m_gfx_ready 1,0,0,1 during a 3-beat packet.
    start_pkt(0, 40, 3);
    step2();
    check_eq("bp_gnt", 32'(a.s_gnt), 32'd1);
    for (int k = 0; k < 6; k++) begin
      a.m_gfx_ready = BpMr[k][0];
      step2();
      check_eq($sformatf("bp_rdy[%0d]", k), 32'(rdy_seen), 32'(BpRdy[k]));
      check_eq($sformatf("bp_mv[%0d]", k), 32'(a.m_gfx_valid), 32'(BpMv[k]));
      check_eq($sformatf("bp_x[%0d]", k), 32'(a.m_gfx_x), 32'(BpX[k]));
      check_eq($sformatf("bp_last[%0d]", k), 32'(a.m_gfx_last), 32'(BpLast[k]));
      check_eq($sformatf("bp_gnt[%0d]", k), 32'(a.s_gnt), 32'(BpGnt[k]));
    end
    a.m_gfx_ready = 1'b1;

    // Isolation: src1 shows valid+last without a grant.
    base[1]  = 99;
    bidx[1]  = 0;
    rogue[1] = 1'b1;
    start_pkt(0, 50, 3);
    for (int k = 0; k < 5; k++) begin
      step2();
      check_eq($sformatf("iso_gnt[%0d]", k), 32'(a.s_gnt), 32'(IsoGnt[k]));
      check_eq($sformatf("iso_rdy[%0d]", k), 32'(rdy_seen), 32'(IsoRdy[k]));
      check_eq($sformatf("iso_mv[%0d]", k), 32'(a.m_gfx_valid), 32'(IsoMv[k]));
      check_eq($sformatf("iso_x[%0d]", k), 32'(a.m_gfx_x), 32'(IsoX[k]));
      check_eq($sformatf("iso_last[%0d]", k), 32'(a.m_gfx_last), 32'(IsoLast[k]));
    end
    rogue = '0;
    drive2();

    // Async reset mid-packet; ptr is 1 here so a fresh ptr shows up as src0 winning.
    start_pkt(0, 60, 4);
    step2();
    check_eq("ar_gnt", 32'(a.s_gnt), 32'd1);
    step2();
    check_eq("ar_x0", 32'(a.m_gfx_x), 32'd60);
    step2();
    check_eq("ar_x1", 32'(a.m_gfx_x), 32'd61);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_mv", 32'(a.m_gfx_valid), 32'd0);
    check_eq("ar_gnt_clr", 32'(a.s_gnt), 32'd0);
    check_eq("ar_rdy", 32'(a.s_gfx_ready), 32'd0);
    check_eq("ar_x_clr", 32'(a.m_gfx_x), 32'd0);
    act = '0;
    drive2();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_pkt(0, 70, 1);
    start_pkt(1, 80, 1);
    step2();
    check_eq("ar_fresh_gnt", 32'(a.s_gnt), 32'd1);
    step2();
    check_eq("ar_fresh_x", 32'(a.m_gfx_x), 32'd70);
    check_eq("ar_fresh_last", 32'(a.m_gfx_last), 32'd1);
    step2();
    check_eq("ar_next_gnt", 32'(a.s_gnt), 32'd2);
    step2();
    check_eq("ar_next_x", 32'(a.m_gfx_x), 32'd80);
    check_eq("ar_next_gnt_rel", 32'(a.s_gnt), 32'd0);

    // Three sources, continuous single-beat packets: order 0,1,2,0,1,2.
    for (int i = 0; i < 3; i++) begin
      b.s_gfx_x[i*HW +: HW] = HW'(i);
    end
    b.s_req = '1;
    b.s_gfx_valid = '1;
    b.s_gfx_last = '1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("wrap_gnt[%0d]", k), 32'(b.s_gnt), 32'(WrapGnt[k]));
      check_eq($sformatf("wrap_mv[%0d]", k), 32'(b.m_gfx_valid), 32'(WrapMv[k]));
      check_eq($sformatf("wrap_x[%0d]", k), 32'(b.m_gfx_x), 32'(WrapX[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
